// File: rtl/tape_prefetch.sv
// Tape image prefetcher: sequential single-outstanding SDRAM byte reads into a
// small FIFO, presented to the cassette waveform generator as a valid/ready stream.
module tape_prefetch #(
   parameter int ADDR_W  = 25,
   parameter int DEPTH   = 4,
   parameter int RD_LAT  = 1,
   parameter int BIT_REV = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    rewind,
   input  logic [ADDR_W-1:0]       tape_end,
   output logic [ADDR_W-1:0]       sdram_addr,
   output logic                    sdram_rd,
   input  logic [7:0]              sdram_data,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    eof
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CAPT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        lat_cnt;
   logic              discard;
   logic              capt;
   logic              push;
   logic              pop;
   logic [7:0]        rev_data;
   logic [7:0]        push_data;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [7:0]        fifo_mem [DEPTH];

   // A FIFO slot is effectively reserved while a read is in flight: a new request
   // is only issued from IDLE, where the in-flight count is zero.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      sdram_rd  = 1'b0;
      capt      = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && !rewind && (sdram_addr != tape_end) && (level < LVL_W'(DEPTH)))
               state_nxt = S_REQ;
         end
         S_REQ: begin
            sdram_rd  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (lat_cnt == 3'd1)
               state_nxt = S_CAPT;
         end
         S_CAPT: begin
            capt      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         lat_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_REQ)
            lat_cnt <= 3'(RD_LAT);
         else if (state == S_WAIT)
            lat_cnt <= lat_cnt - 3'd1;
      end
   end

   always_comb begin
      rev_data = '0;
      for (int i = 0; i < 8; i++)
         rev_data[i] = sdram_data[7-i];
   end

   assign push_data  = (BIT_REV != 0) ? rev_data : sdram_data;
   assign push       = capt && !discard && !rewind;
   assign pop        = byte_valid && byte_ready && !rewind;
   assign byte_valid = (level != '0);
   assign byte_out   = fifo_mem[rd_ptr];

   // NOTE: FIFO storage is not reset; level/pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= push_data;
   end

   // A read that was in flight when rewind hit still runs to CAPT, but its data
   // belongs to the old position and must not be pushed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         discard <= 1'b0;
      end else if (state == S_CAPT) begin
         discard <= 1'b0;
      end else if (rewind && (state != S_IDLE)) begin
         discard <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sdram_addr <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
      end else if (rewind) begin
         sdram_addr <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
      end else begin
         if (push) begin
            sdram_addr <= sdram_addr + ADDR_W'(1);
            wr_ptr     <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         eof <= 1'b0;
      else if (rewind)
         eof <= 1'b0;
      else
         eof <= (sdram_addr == tape_end) && (state == S_IDLE) && (level == '0);
   end

endmodule
